pio_bank: RTL and testbench

Parametrised Avalon-MM parallel-I/O bank that replaces the separate fixed-width LED, hex, switch and input PIO slaves behind the PCIe bridge with a single slave. It provides N_OUT registered output channels and N_IN synchronised input channels. Each input bit has rising-edge capture with a per-bit interrupt mask and one level interrupt to the host. It sits on the PCIe-to-Avalon interconnect; host software reaches it through BAR-mapped word addresses.

---
 rtl/pio_bank_pkg.sv | 29 ++
 rtl/pio_bank_debounce.sv | 36 +++
 rtl/pio_bank.sv | 158 +++++++++++++++
 tb/tb_pio_bank.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/pio_bank_pkg.sv
// pio_bank_pkg: register map constants and address decode helpers shared by
// the pio_bank parallel-I/O slave.
package pio_bank_pkg;

    localparam int ADDR_W = 5;
    localparam int MAX_CH = 8;

    localparam logic [ADDR_W-1:0] OFS_OUT  = 5'h00;
    localparam logic [ADDR_W-1:0] OFS_IN   = 5'h08;
    localparam logic [ADDR_W-1:0] OFS_EDGE = 5'h10;
    localparam logic [ADDR_W-1:0] OFS_MASK = 5'h18;

    // Register group selected by the upper two address bits.
    typedef enum logic [1:0] {
        GRP_OUT  = 2'(OFS_OUT  >> 3),
        GRP_IN   = 2'(OFS_IN   >> 3),
        GRP_EDGE = 2'(OFS_EDGE >> 3),
        GRP_MASK = 2'(OFS_MASK >> 3)
    } reg_grp_e;

    function automatic reg_grp_e addr_grp(input logic [ADDR_W-1:0] a);
        return reg_grp_e'(a[4:3]);
    endfunction

    function automatic logic [$clog2(MAX_CH)-1:0] addr_ch(input logic [ADDR_W-1:0] a);
        return a[$clog2(MAX_CH)-1:0];
    endfunction

endpackage

// File: rtl/pio_bank_debounce.sv
// pio_debounce: single-bit debounce filter. The output follows the input only
// after the input has disagreed with it for DEBOUNCE_CYC consecutive cycles.
module pio_debounce #(
    parameter int DEBOUNCE_CYC = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic i_d,
    output logic o_q
);

    localparam int CW = $clog2(DEBOUNCE_CYC);

    logic [CW-1:0] r_cnt;
    logic          r_q;

    // Count disagreeing cycles; flip the output when the run is long enough.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
            r_q   <= 1'b0;
        end else if (i_d != r_q) begin
            if (r_cnt == CW'(DEBOUNCE_CYC - 1)) begin
                r_q   <= i_d;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end else begin
            r_cnt <= '0;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/pio_bank.sv
// pio_bank: Avalon-MM parallel-I/O bank with N_OUT output channels, N_IN
// synchronised input channels, rising-edge capture and a masked level irq.
// Optional build macro: PIO_BANK_DEBOUNCE_EN inserts a per-bit debounce filter
// after the input synchroniser.
module pio_bank
    import pio_bank_pkg::*;
#(
    parameter int          DATA_W       = 32,
    parameter int          N_OUT        = 4,
    parameter int          N_IN         = 2,
    parameter logic [31:0] OUT_RESET    = 32'd0,
    parameter int          DEBOUNCE_CYC = 50000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [ADDR_W-1:0]       address,
    input  logic                    read,
    input  logic                    write,
    input  logic [DATA_W-1:0]       writedata,
    output logic [DATA_W-1:0]       readdata,
    output logic                    readdatavalid,
    output logic [N_OUT*DATA_W-1:0] out_port,
    input  logic [N_IN*DATA_W-1:0]  in_port,
    output logic                    irq
);

    localparam int CH_W = $clog2(MAX_CH);

    if (N_OUT < 1 || N_OUT > MAX_CH || N_IN < 1 || N_IN > MAX_CH ||
        DATA_W < 1 || DATA_W > 32 || DEBOUNCE_CYC < 2) begin : g_bad_cfg
        $error("pio_bank: parameter out of range");
    end

    reg_grp_e               w_grp;
    logic [CH_W-1:0]        w_ch;
    logic [N_OUT*DATA_W-1:0] r_out;
    logic [N_IN*DATA_W-1:0] r_sync1;
    logic [N_IN*DATA_W-1:0] r_sync2;
    logic [N_IN*DATA_W-1:0] w_filt;
    logic [N_IN*DATA_W-1:0] r_filt_d;
    logic [N_IN*DATA_W-1:0] w_rise;
    logic [N_IN*DATA_W-1:0] w_edge_clr;
    logic [N_IN*DATA_W-1:0] r_edge;
    logic [N_IN*DATA_W-1:0] r_mask;
    logic [DATA_W-1:0]      w_rdata;
    logic [DATA_W-1:0]      r_readdata;
    logic                   r_rdv;
    logic                   r_irq;

    assign w_grp = addr_grp(address);
    assign w_ch  = addr_ch(address);

`ifdef PIO_BANK_DEBOUNCE_EN
    for (genvar b = 0; b < N_IN*DATA_W; b++) begin : g_db
        pio_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db (
            .clk   (clk),
            .reset (reset),
            .i_d   (r_sync2[b]),
            .o_q   (w_filt[b])
        );
    end
`else
    assign w_filt = r_sync2;
`endif

    assign w_rise = w_filt & ~r_filt_d;

    // Two-flop synchroniser plus the delayed filtered value for edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_filt_d <= '0;
        end else begin
            r_sync1  <= in_port;
            r_sync2  <= r_sync1;
            r_filt_d <= w_filt;
        end
    end

    // W1C clear vector for the addressed edge-capture channel.
    always_comb begin
        w_edge_clr = '0;
        if (write && w_grp == GRP_EDGE) begin
            for (int unsigned j = 0; j < N_IN; j++) begin
                if (w_ch == CH_W'(j)) w_edge_clr[j*DATA_W +: DATA_W] = writedata;
            end
        end
    end

    // Output and mask registers, plus edge capture where a new edge beats W1C.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out  <= {N_OUT{OUT_RESET[DATA_W-1:0]}};
            r_mask <= '0;
            r_edge <= '0;
        end else begin
            r_edge <= (r_edge & ~w_edge_clr) | w_rise;
            if (write && w_grp == GRP_OUT) begin
                for (int unsigned k = 0; k < N_OUT; k++) begin
                    if (w_ch == CH_W'(k)) r_out[k*DATA_W +: DATA_W] <= writedata;
                end
            end
            if (write && w_grp == GRP_MASK) begin
                for (int unsigned j = 0; j < N_IN; j++) begin
                    if (w_ch == CH_W'(j)) r_mask[j*DATA_W +: DATA_W] <= writedata;
                end
            end
        end
    end

    // Read mux; unmapped channels fall through to zero.
    always_comb begin
        w_rdata = '0;
        unique case (w_grp)
            GRP_OUT: begin
                for (int unsigned k = 0; k < N_OUT; k++) begin
                    if (w_ch == CH_W'(k)) w_rdata = r_out[k*DATA_W +: DATA_W];
                end
            end
            GRP_IN: begin
                for (int unsigned j = 0; j < N_IN; j++) begin
                    if (w_ch == CH_W'(j)) w_rdata = w_filt[j*DATA_W +: DATA_W];
                end
            end
            GRP_EDGE: begin
                for (int unsigned j = 0; j < N_IN; j++) begin
                    if (w_ch == CH_W'(j)) w_rdata = r_edge[j*DATA_W +: DATA_W];
                end
            end
            GRP_MASK: begin
                for (int unsigned j = 0; j < N_IN; j++) begin
                    if (w_ch == CH_W'(j)) w_rdata = r_mask[j*DATA_W +: DATA_W];
                end
            end
            default: w_rdata = '0;
        endcase
    end

    // Registered read response and interrupt; reads see pre-write state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_readdata <= '0;
            r_rdv      <= 1'b0;
            r_irq      <= 1'b0;
        end else begin
            r_rdv <= read;
            if (read) r_readdata <= w_rdata;
            r_irq <= |(r_edge & r_mask);
        end
    end

    assign out_port      = r_out;
    assign readdata      = r_readdata;
    assign readdatavalid = r_rdv;
    assign irq           = r_irq;

endmodule

// File: tb/tb_pio_bank.sv
// tb_pio_bank: directed stimulus for pio_bank with a read-response scoreboard.
// Reads push their expected value; a negedge monitor pops on readdatavalid.
module tb_pio_bank;

    localparam logic [31:0] OUT_RST = 32'h1234_5678;
`ifdef PIO_BANK_DEBOUNCE_EN
    localparam int LAT = 8;
`else
    localparam int LAT = 0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic [4:0]   address;
    logic         read;
    logic         write;
    logic [31:0]  writedata;
    logic [31:0]  readdata;
    logic         readdatavalid;
    logic [127:0] out_port;
    logic [63:0]  in_port;
    logic         irq;

    int total = 0;
    int bad   = 0;

    logic [31:0] q_exp[$];
    string       q_name[$];

    pio_bank #(
        .DATA_W       (32),
        .N_OUT        (4),
        .N_IN         (2),
        .OUT_RESET    (OUT_RST),
        .DEBOUNCE_CYC (8)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .address       (address),
        .read          (read),
        .write         (write),
        .writedata     (writedata),
        .readdata      (readdata),
        .readdatavalid (readdatavalid),
        .out_port      (out_port),
        .in_port       (in_port),
        .irq           (irq)
    );

    always #5 clk = ~clk;

    // Monitor: every readdatavalid must match the oldest outstanding read.
    always @(negedge clk) begin
        if (readdatavalid) begin
            total++;
            if (q_exp.size() == 0) begin
                bad++;
                $display("FAIL unexpected_rdv: got readdata %h with no read outstanding", readdata);
            end else begin
                logic [31:0] e;
                string       n;
                e = q_exp.pop_front();
                n = q_name.pop_front();
                if (readdata !== e) begin
                    bad++;
                    $display("FAIL %s: got %h expected %h", n, readdata, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [4:0] a, input logic [31:0] e, input string n);
        address = a;
        read    = 1'b1;
        q_exp.push_back(e);
        q_name.push_back(n);
        tick();
        read = 1'b0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        address   = a;
        writedata = d;
        write     = 1'b1;
        tick();
        write = 1'b0;
    endtask

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    initial begin
        reset     = 1'b1;
        address   = '0;
        read      = 1'b0;
        write     = 1'b0;
        writedata = '0;
        in_port   = '0;
        repeat (3) tick();
        chk("rst_irq", {31'd0, irq}, 32'd0);
        chk("rst_rdv", {31'd0, readdatavalid}, 32'd0);
        reset = 1'b0;
        tick();
        for (int k = 0; k < 4; k++) chk("rst_out", out_port[k*32 +: 32], OUT_RST);

        // Output channels read back their reset value.
        for (int k = 0; k < 4; k++) rd(5'(k), OUT_RST, "rd_out_rst");
        chk("irq_idle", {31'd0, irq}, 32'd0);

        // Output write, unmapped and read-only addresses.
        wr(5'h02, 32'hDEAD_BEEF);
        chk("out2_wr", out_port[95:64], 32'hDEAD_BEEF);
        rd(5'h02, 32'hDEAD_BEEF, "rd_out2");
        rd(5'h05, 32'h0, "rd_unmapped_out5");
        wr(5'h05, 32'hFFFF_FFFF);
        chk("out0_keep", out_port[31:0], OUT_RST);
        chk("out1_keep", out_port[63:32], OUT_RST);
        chk("out2_keep", out_port[95:64], 32'hDEAD_BEEF);
        chk("out3_keep", out_port[127:96], OUT_RST);
        rd(5'h05, 32'h0, "rd_out5_after_wr");
        wr(5'h08, 32'hFFFF_FFFF);
        rd(5'h08, 32'h0, "rd_in0_ro");
        rd(5'h0A, 32'h0, "rd_in2_unmapped");
        rd(5'h1F, 32'h0, "rd_mask7_unmapped");

        // Input bit 0 rising edge: IN after 2 edges, EDGE after 3, irq after 4.
        wr(5'h18, 32'h1);
        rd(5'h18, 32'h1, "rd_mask0");
        in_port[0] = 1'b1;
        tick();
        repeat (LAT) tick();
        rd(5'h08, 32'h0, "in0_not_yet");
        chk("irq_e2", {31'd0, irq}, 32'd0);
        rd(5'h08, 32'h1, "in0_after2");
        chk("irq_e3", {31'd0, irq}, 32'd0);
        rd(5'h10, 32'h1, "edge0_after3");
        chk("irq_e4", {31'd0, irq}, 32'd1);
        wr(5'h10, 32'h1);
        chk("irq_w1c_e0", {31'd0, irq}, 32'd1);
        tick();
        chk("irq_w1c_e1", {31'd0, irq}, 32'd0);
        rd(5'h10, 32'h0, "edge0_cleared");

        // Channel 1 bit 3: capture, fall, then a new edge meets a W1C.
        wr(5'h19, 32'h8);
        in_port[35] = 1'b1;
        repeat (4 + LAT) tick();
        chk("irq_ch1", {31'd0, irq}, 32'd1);
        in_port[35] = 1'b0;
        repeat (4 + LAT) tick();
        in_port[35] = 1'b1;
        repeat (2 + LAT) tick();
        wr(5'h11, 32'h8);
        tick();
        chk("irq_setwins", {31'd0, irq}, 32'd1);
        rd(5'h11, 32'h8, "edge1_setwins");
        wr(5'h19, 32'h0);
        chk("irq_unmask_e0", {31'd0, irq}, 32'd1);
        tick();
        chk("irq_unmask_e1", {31'd0, irq}, 32'd0);
        wr(5'h11, 32'h8);
        rd(5'h11, 32'h0, "edge1_cleared");

`ifdef PIO_BANK_DEBOUNCE_EN
        // 5-cycle glitch is filtered out; 10-cycle pulse is accepted.
        in_port[1] = 1'b1;
        repeat (5) tick();
        in_port[1] = 1'b0;
        repeat (20) tick();
        rd(5'h08, 32'h1, "db_glitch_in");
        rd(5'h10, 32'h0, "db_glitch_edge");
        in_port[2] = 1'b1;
        repeat (9) tick();
        rd(5'h08, 32'h1, "db_pulse_not_yet");
        in_port[2] = 1'b0;
        rd(5'h08, 32'h5, "db_pulse_in");
        repeat (20) tick();
        rd(5'h10, 32'h4, "db_pulse_edge");
`endif

        // Reset during a pending read after outputs and irq were set up.
        wr(5'h01, 32'hCAFE_0001);
        wr(5'h18, 32'hFF);
        in_port[4] = 1'b1;
        repeat (4 + LAT) tick();
        chk("irq_pre_rst", {31'd0, irq}, 32'd1);
        in_port = '0;
        address = 5'h19;
        read    = 1'b1;
        reset   = 1'b1;
        tick();
        read  = 1'b0;
        reset = 1'b0;
        tick();
        tick();
        for (int k = 0; k < 4; k++) chk("out_after_rst", out_port[k*32 +: 32], OUT_RST);
        chk("irq_after_rst", {31'd0, irq}, 32'd0);
        rd(5'h18, 32'h0, "mask_after_rst");
        rd(5'h10, 32'h0, "edge_after_rst");
        rd(5'h01, OUT_RST, "out1_after_rst");

        // Drain outstanding reads with a bounded wait.
        for (int i = 0; i < 10 && q_exp.size() != 0; i++) tick();
        if (q_exp.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d reads outstanding expected 0", q_exp.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
